// File: rtl/twowire_pkg.sv
// twowire_pkg: shared types and constants for the two-wire frame link.
// Frame length helper is used by the transmitter, the receiver and the bench.
package twowire_pkg;

   typedef enum logic [2:0] {
      TW_IDLE,
      TW_START,
      TW_DATA,
      TW_PAR,
      TW_GAPW
   } tw_state_t;

   localparam logic TW_START_BIT = 1'b1;
   localparam logic TW_IDLE_LVL  = 1'b0;

   // Strobe-high cycles per frame: start marker, payload, optional parity.
   function automatic int tw_frame_len(input int data_w, input bit parity_en);
      return data_w + 1 + (parity_en ? 1 : 0);
   endfunction

endpackage

// File: rtl/twowire_shreg.sv
// twowire_shreg: DATA_W-bit load / shift-right register for the transmitter.
// lsb is the next bit to send; par accumulates the XOR of every bit shifted
// out since the last load, so after all bits have left it holds even parity.
module twowire_shreg
   import twowire_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] d,
   output logic              lsb,
   output logic              par
);

   logic [DATA_W-1:0] q;
   logic              par_q;

   // Load takes priority over shift; zeros fill in from the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q     <= '0;
         par_q <= 1'b0;
      end else if (load) begin
         q     <= d;
         par_q <= 1'b0;
      end else if (shift) begin
         q     <= {1'b0, q[DATA_W-1:1]};
         par_q <= par_q ^ q[0];
      end
   end

   assign lsb = q[0];
   assign par = par_q;

endmodule

// File: rtl/twowire_tx.sv
// twowire_tx: two-wire frame transmitter (tx_d0 data, tx_d1 frame strobe).
// Optional parity bit enabled by defining TWOWIRE_PARITY_EN.
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | in_ready high, lines low, waiting for a word
// START  | start marker on the lines (d1=1, d0=1)
// DATA   | payload bit bit_idx on d0, LSB first
// PAR    | even parity of the word on d0 (parity build only)
// GAPW   | lines low for GAP extra cycles before IDLE
//
// Every output is a flop loaded from the next-state logic, so the value
// seen after an edge is the one belonging to the state entered on it.
module twowire_tx
   import twowire_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int GAP    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              tx_d0,
   output logic              tx_d1,
   output logic              busy
);

   localparam int             BW       = $clog2(DATA_W);
   localparam logic [BW-1:0]  LAST_IDX = BW'(DATA_W - 1);
   localparam logic [3:0]     GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   tw_state_t     state, state_nx;
   logic [BW-1:0] bit_idx, bit_idx_nx;
   logic [3:0]    gap_cnt, gap_cnt_nx;
   logic          d0_nx, d1_nx, rdy_nx, busy_nx;
   logic          sh_load, sh_shift, sh_lsb, sh_par;
   logic          frame_end;

   twowire_shreg #(.DATA_W(DATA_W)) u_shreg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (sh_load),
      .shift (sh_shift),
      .d     (in_data),
      .lsb   (sh_lsb),
      .par   (sh_par)
   );

`ifndef TWOWIRE_PARITY_EN
   logic unused_par;
   assign unused_par = sh_par;
`endif

   // Next state, counters and the output values for the coming cycle.
   always_comb begin
      state_nx   = state;
      bit_idx_nx = bit_idx;
      gap_cnt_nx = gap_cnt;
      d0_nx      = TW_IDLE_LVL;
      d1_nx      = 1'b0;
      rdy_nx     = 1'b0;
      sh_load    = 1'b0;
      sh_shift   = 1'b0;
      frame_end  = 1'b0;
      case (state)
         TW_IDLE: begin
            rdy_nx = 1'b1;
            if (in_valid && in_ready) begin
               sh_load  = 1'b1;
               state_nx = TW_START;
               d1_nx    = 1'b1;
               d0_nx    = TW_START_BIT;
               rdy_nx   = 1'b0;
            end
         end
         TW_START: begin
            state_nx   = TW_DATA;
            bit_idx_nx = '0;
            d1_nx      = 1'b1;
            d0_nx      = sh_lsb;
            sh_shift   = 1'b1;
         end
         TW_DATA: begin
            if (bit_idx == LAST_IDX) begin
`ifdef TWOWIRE_PARITY_EN
               state_nx = TW_PAR;
               d1_nx    = 1'b1;
               d0_nx    = sh_par;
`else
               frame_end = 1'b1;
`endif
            end else begin
               bit_idx_nx = bit_idx + 1'b1;
               d1_nx      = 1'b1;
               d0_nx      = sh_lsb;
               sh_shift   = 1'b1;
            end
         end
         TW_PAR: begin
            frame_end = 1'b1;
         end
         TW_GAPW: begin
            if (gap_cnt == 4'd0) begin
               state_nx = TW_IDLE;
               rdy_nx   = 1'b1;
            end else begin
               gap_cnt_nx = gap_cnt - 4'd1;
            end
         end
         default: begin
            state_nx = TW_IDLE;
         end
      endcase
      // The strobe drops here; the mandatory idle cycle is the first of GAPW
      // or, with no extra gap, the IDLE cycle itself.
      if (frame_end) begin
         if (GAP == 0) begin
            state_nx = TW_IDLE;
            rdy_nx   = 1'b1;
         end else begin
            state_nx   = TW_GAPW;
            gap_cnt_nx = GAP_LOAD;
         end
      end
      busy_nx = (state_nx != TW_IDLE);
   end

   // State, counters and output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= TW_IDLE;
         bit_idx  <= '0;
         gap_cnt  <= 4'd0;
         tx_d0    <= 1'b0;
         tx_d1    <= 1'b0;
         in_ready <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         bit_idx  <= bit_idx_nx;
         gap_cnt  <= gap_cnt_nx;
         tx_d0    <= d0_nx;
         tx_d1    <= d1_nx;
         in_ready <= rdy_nx;
         busy     <= busy_nx;
      end
   end

endmodule

// File: tb/tb_twowire_tx.sv
// tb_twowire_tx: directed bench for twowire_tx.
// Instance a: DATA_W=8, GAP=1.  Instance b: DATA_W=2, GAP=0.
module tb_twowire_tx;
   import twowire_pkg::*;

`ifdef TWOWIRE_PARITY_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_valid, b_valid;
   logic [7:0] a_data;
   logic [1:0] b_data;
   logic       a_rdy, a_d0, a_d1, a_busy;
   logic       b_rdy, b_d0, b_d1, b_busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   twowire_tx #(.DATA_W(8), .GAP(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_data(a_data),
      .in_ready(a_rdy), .tx_d0(a_d0), .tx_d1(a_d1), .busy(a_busy)
   );

   twowire_tx #(.DATA_W(2), .GAP(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_data(b_data),
      .in_ready(b_rdy), .tx_d0(b_d0), .tx_d1(b_d1), .busy(b_busy)
   );

   task automatic chk(input string name, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", name, obs, exp);
      end
   endtask

   function automatic logic o_d0(input int sel);   return sel != 0 ? b_d0   : a_d0;   endfunction
   function automatic logic o_d1(input int sel);   return sel != 0 ? b_d1   : a_d1;   endfunction
   function automatic logic o_rdy(input int sel);  return sel != 0 ? b_rdy  : a_rdy;  endfunction
   function automatic logic o_busy(input int sel); return sel != 0 ? b_busy : a_busy; endfunction

   task automatic set_in(input int sel, input logic v, input logic [31:0] d);
      if (sel != 0) begin
         b_valid = v;
         b_data  = d[1:0];
      end else begin
         a_valid = v;
         a_data  = d[7:0];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer word, then check the whole frame and the idle gap that follows.
   // After the accept edge the inputs become (nv, nd): nv=1 queues the next word.
   task automatic frame(input int sel, input logic [31:0] word,
                        input logic nv, input logic [31:0] nd, input string tag);
      int          dw, gap, flen;
      logic [31:0] m;
      logic        par;
      dw   = (sel != 0) ? 2 : 8;
      gap  = (sel != 0) ? 0 : 1;
      flen = tw_frame_len(dw, PEN);
      m    = word & ((32'd1 << dw) - 32'd1);
      par  = ^m;
      set_in(sel, 1'b1, word);
      tick();
      chk({tag, "_start_d1"}, o_d1(sel), 1'b1);
      chk({tag, "_start_d0"}, o_d0(sel), 1'b1);
      chk({tag, "_start_rdy"}, o_rdy(sel), 1'b0);
      chk({tag, "_start_busy"}, o_busy(sel), 1'b1);
      set_in(sel, nv, nd);
      for (int i = 0; i < flen - 1; i++) begin
         tick();
         chk($sformatf("%s_bit%0d_d1", tag, i), o_d1(sel), 1'b1);
         chk($sformatf("%s_bit%0d_d0", tag, i), o_d0(sel), (i < dw) ? m[i] : par);
      end
      for (int g = 0; g < gap; g++) begin
         tick();
         chk($sformatf("%s_gap%0d_d1", tag, g), o_d1(sel), 1'b0);
         chk($sformatf("%s_gap%0d_d0", tag, g), o_d0(sel), 1'b0);
         chk($sformatf("%s_gap%0d_rdy", tag, g), o_rdy(sel), 1'b0);
         chk($sformatf("%s_gap%0d_busy", tag, g), o_busy(sel), 1'b1);
      end
      tick();
      chk({tag, "_idle_d1"}, o_d1(sel), 1'b0);
      chk({tag, "_idle_d0"}, o_d0(sel), 1'b0);
      chk({tag, "_idle_rdy"}, o_rdy(sel), 1'b1);
      chk({tag, "_idle_busy"}, o_busy(sel), 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      a_valid = 1'b0;
      a_data  = 8'h00;
      b_valid = 1'b0;
      b_data  = 2'b00;

      // Reset state, before and across clock edges.
      #3;
      chk("rst_a_d0", a_d0, 1'b0);
      chk("rst_a_d1", a_d1, 1'b0);
      chk("rst_a_rdy", a_rdy, 1'b0);
      chk("rst_a_busy", a_busy, 1'b0);
      chk("rst_b_rdy", b_rdy, 1'b0);
      tick();
      tick();
      chk("rst_hold_a_rdy", a_rdy, 1'b0);
      chk("rst_hold_a_d1", a_d1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rel_a_rdy", a_rdy, 1'b1);
      chk("rel_b_rdy", b_rdy, 1'b1);
      chk("rel_a_busy", a_busy, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("quiet%0d_a_d1", i), a_d1, 1'b0);
      end

      // Single word 0xA5.
      frame(0, 32'hA5, 1'b0, 32'h00, "a5");

      // Back-to-back with in_valid held: 0x01 then 0x80.
      frame(0, 32'h01, 1'b1, 32'h80, "b2b0");
      frame(0, 32'h80, 1'b0, 32'h00, "b2b1");

      // Latched word unaffected by in_data changing after accept.
      frame(0, 32'h3C, 1'b0, 32'hFF, "stab");

      // Reset in the middle of a frame (0xCB, bit 3 = 1).
      set_in(0, 1'b1, 32'hCB);
      tick();
      chk("mid_start_d1", a_d1, 1'b1);
      set_in(0, 1'b0, 32'h00);
      for (int i = 0; i < 4; i++) tick();
      chk("mid_bit3_d1", a_d1, 1'b1);
      chk("mid_bit3_d0", a_d0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_d1", a_d1, 1'b0);
      chk("mid_rst_d0", a_d0, 1'b0);
      chk("mid_rst_busy", a_busy, 1'b0);
      chk("mid_rst_rdy", a_rdy, 1'b0);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("mid_rel_rdy", a_rdy, 1'b1);
      chk("mid_rel_d1", a_d1, 1'b0);
      frame(0, 32'h5A, 1'b0, 32'h00, "fresh");

      // GAP=0, DATA_W=2: 0x2 then 0x1 with in_valid held.
      frame(1, 32'h2, 1'b1, 32'h1, "g0a");
      frame(1, 32'h1, 1'b0, 32'h0, "g0b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
